// File: rtl/data_ram_arbiter_if.sv
// rtl/data_ram_arbiter_if.sv - master-side request bus and RAM-side drive for the data RAM arbiter
interface data_ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]             m_req;
  logic [1:0]             m_lock;
  logic [1:0]             m_we;
  logic [1:0][3:0]        m_sel;
  logic [1:0][ADDR_W-1:0] m_addr;
  logic [1:0][DATA_W-1:0] m_wdata;
  logic [1:0]             m_gnt;
  logic [1:0]             m_rvalid;
  logic [DATA_W-1:0]      m_rdata;
  logic                   cpu_stall;
  logic                   ram_ce;
  logic                   ram_we;
  logic [3:0]             ram_sel;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_wdata;
  logic [DATA_W-1:0]      ram_rdata;

  modport slave (
    input  m_req, m_lock, m_we, m_sel, m_addr, m_wdata, ram_rdata,
    output m_gnt, m_rvalid, m_rdata, cpu_stall,
           ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
  );

  modport master (
    output m_req, m_lock, m_we, m_sel, m_addr, m_wdata, ram_rdata,
    input  m_gnt, m_rvalid, m_rdata, cpu_stall,
           ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - round-robin two-master arbiter with bounded lock in front of the single-port data RAM
module data_ram_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  data_ram_arbiter_if.slave bus
);
  localparam int   CNT_W        = $clog2(LOCK_MAX) + 1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        gnt;
  logic [1:0]        gnt_o;
  logic              lock_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    gnt        = 2'b00;
    lock_hold  = 1'b0;
    state_d    = IDLE;
    last_d     = last_q;
    lock_cnt_d = '0;
    // A lock only survives while its owner keeps both lock and req and the budget is not spent
    if (state_q == OWN0 && bus.m_req[0] && bus.m_lock[0] &&
        lock_cnt_q < CNT_W'(LOCK_MAX - 1)) begin
      gnt       = 2'b01;
      lock_hold = 1'b1;
    end else if (state_q == OWN1 && bus.m_req[1] && bus.m_lock[1] &&
                 lock_cnt_q < CNT_W'(LOCK_MAX - 1)) begin
      gnt       = 2'b10;
      lock_hold = 1'b1;
    end else if (bus.m_req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = bus.m_req;
    end

    if (gnt[0]) last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;

    if (gnt[0] && bus.m_lock[0]) state_d = OWN0;
    else if (gnt[1] && bus.m_lock[1]) state_d = OWN1;

    if (lock_hold) lock_cnt_d = lock_cnt_q + CNT_W'(1);
    else if (state_d == state_q && state_d != IDLE) lock_cnt_d = lock_cnt_q;

    rvalid_d = {gnt[1] & ~bus.m_we[1], gnt[0] & ~bus.m_we[0]};
    rdata_d  = (|rvalid_d) ? bus.ram_rdata : rdata_q;
  end

  always_comb begin
    gnt_o         = rst ? 2'b00 : gnt;
    bus.m_gnt     = gnt_o;
    bus.cpu_stall = bus.m_req[0] & ~gnt_o[0];
    bus.m_rvalid  = rvalid_q;
    bus.m_rdata   = rdata_q;
    bus.ram_ce    = CHIP_DISABLE;
    bus.ram_we    = 1'b0;
    bus.ram_sel   = 4'b0000;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (gnt_o[0]) begin
      bus.ram_ce    = CHIP_ENABLE;
      bus.ram_we    = bus.m_we[0];
      bus.ram_sel   = bus.m_sel[0];
      bus.ram_addr  = bus.m_addr[0];
      bus.ram_wdata = bus.m_wdata[0];
    end else if (gnt_o[1]) begin
      bus.ram_ce    = CHIP_ENABLE;
      bus.ram_we    = bus.m_we[1];
      bus.ram_sel   = bus.m_sel[1];
      bus.ram_addr  = bus.m_addr[1];
      bus.ram_wdata = bus.m_wdata[1];
    end
  end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter with a RAM and reference arbiter model
module tb_data_ram_arbiter;
  localparam int LOCK_MAX = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] mem [0:127];

  int          m_last;
  int          chain;
  int          run_len;
  logic [1:0]  e_rvalid;
  logic [31:0] e_rdata;

  data_ram_arbiter_if bus ();

  data_ram_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ram_rdata = mem[bus.ram_addr[8:2]];

  always @(posedge clk) begin
    if (!rst && bus.ram_ce && bus.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_sel[b]) mem[bus.ram_addr[8:2]][8*b +: 8] = bus.ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arbiter: round-robin on ties, a locked owner keeps the port for at most LOCK_MAX grants in a row
  always @(negedge clk) begin
    int          win;
    logic [1:0]  eg;
    logic [31:0] a;
    if (rst) begin
      chk("rst_gnt", bus.m_gnt, 0);
      chk("rst_ce", bus.ram_ce, 0);
      chk("rst_ram_bus", {bus.ram_we, bus.ram_sel, bus.ram_addr[26:0]}, 0);
      chk("rst_wdata", bus.ram_wdata, 0);
      chk("rst_rvalid", bus.m_rvalid, 0);
      chk("rst_rdata", bus.m_rdata, 0);
      m_last   = 1;
      chain    = -1;
      run_len  = 0;
      e_rvalid = 2'b00;
      e_rdata  = 32'h0;
    end else begin
      if (chain >= 0 && bus.m_req[chain] && bus.m_lock[chain] && run_len < LOCK_MAX) win = chain;
      else if (bus.m_req == 2'b11) win = 1 - m_last;
      else if (bus.m_req[0]) win = 0;
      else if (bus.m_req[1]) win = 1;
      else win = -1;
      eg = (win < 0) ? 2'b00 : (2'b01 << win);

      chk("gnt", bus.m_gnt, eg);
      chk("ce", bus.ram_ce, (win >= 0));
      chk("stall", bus.cpu_stall, bus.m_req[0] && win != 0);
      chk("ram_we", bus.ram_we, (win >= 0) ? bus.m_we[win] : 1'b0);
      chk("ram_sel", bus.ram_sel, (win >= 0) ? bus.m_sel[win] : 4'h0);
      chk("ram_addr", bus.ram_addr, (win >= 0) ? bus.m_addr[win] : 32'h0);
      chk("ram_wdata", bus.ram_wdata, (win >= 0) ? bus.m_wdata[win] : 32'h0);
      chk("rvalid", bus.m_rvalid, e_rvalid);
      chk("rdata", bus.m_rdata, e_rdata);

      e_rvalid = 2'b00;
      if (win >= 0) begin
        m_last = win;
        if (!bus.m_we[win]) begin
          a        = bus.m_addr[win];
          e_rvalid = eg;
          e_rdata  = mem[a[8:2]];
        end
        if (bus.m_lock[win]) begin
          run_len = (chain == win) ? run_len + 1 : 1;
          chain   = win;
        end else begin
          chain   = -1;
          run_len = 0;
        end
      end else begin
        chain   = -1;
        run_len = 0;
      end
    end
  end

  task automatic idle_inputs();
    bus.m_req   = 2'b00;
    bus.m_lock  = 2'b00;
    bus.m_we    = 2'b00;
    bus.m_sel   = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
  endtask

  task automatic set_p(input int p, input logic req, input logic lock, input logic we,
                       input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m_req[p]   = req;
    bus.m_lock[p]  = lock;
    bus.m_we[p]    = we;
    bus.m_sel[p]   = sel;
    bus.m_addr[p]  = addr;
    bus.m_wdata[p] = wdata;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    for (int i = 0; i < 128; i++) mem[i] = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'hAABB_CCDD;
    mem[9] = 32'h55AA_55AA;

    to_neg();
    chk("t0_rst_gnt", bus.m_gnt, 2'b00);
    chk("t0_rst_ce", bus.ram_ce, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single CPU read
    set_p(0, 1, 0, 0, 4'hF, 32'h10, 0);
    to_neg();
    chk("t1_gnt", bus.m_gnt, 2'b01);
    chk("t1_stall", bus.cpu_stall, 1'b0);
    to_next();
    idle_inputs();
    to_neg();
    chk("t1_rvalid", bus.m_rvalid, 2'b01);
    chk("t1_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    to_next();

    rst = 1'b1;
    to_next();
    rst = 1'b0;

    // 2: continuous contention alternates
    for (int c = 1; c <= 6; c++) begin
      set_p(0, 1, 0, 0, 4'hF, 32'h10, 0);
      set_p(1, 1, 0, 0, 4'hF, 32'h14, 0);
      to_neg();
      chk("t2_gnt", bus.m_gnt, (c % 2) ? 2'b01 : 2'b10);
      chk("t2_stall", bus.cpu_stall, (c % 2) == 0);
      to_next();
    end
    idle_inputs();

    // 3: partial write then read back, then an all-zero byte-enable write
    set_p(1, 1, 0, 1, 4'b0101, 32'h20, 32'h1122_3344);
    to_neg();
    chk("t3_wr_gnt", bus.m_gnt, 2'b10);
    to_next();
    idle_inputs();
    set_p(0, 1, 0, 0, 4'hF, 32'h20, 0);
    to_neg();
    chk("t3_rd_gnt", bus.m_gnt, 2'b01);
    to_next();
    idle_inputs();
    to_neg();
    chk("t3_rdata", bus.m_rdata, 32'hAA22_CC44);
    chk("t3_rvalid", bus.m_rvalid, 2'b01);
    to_next();
    set_p(1, 1, 0, 1, 4'b0000, 32'h20, 32'hFFFF_FFFF);
    to_neg();
    chk("t3_sel0_gnt", bus.m_gnt, 2'b10);
    to_next();
    idle_inputs();
    set_p(0, 1, 0, 0, 4'hF, 32'h20, 0);
    to_neg();
    to_next();
    idle_inputs();
    to_neg();
    chk("t3_sel0_rdata", bus.m_rdata, 32'hAA22_CC44);
    to_next();

    // 4: port1 lock runs out after LOCK_MAX grants
    for (int c = 1; c <= 5; c++) begin
      set_p(1, 1, 1, 0, 4'hF, 32'h24, 0);
      set_p(0, 1, 0, 0, 4'hF, 32'h10, 0);
      to_neg();
      chk("t4_gnt", bus.m_gnt, (c <= 4) ? 2'b10 : 2'b01);
      to_next();
    end
    idle_inputs();

    // 5: idle cycles keep rdata
    for (int c = 1; c <= 3; c++) begin
      to_neg();
      chk("t5_gnt", bus.m_gnt, 2'b00);
      chk("t5_ce", bus.ram_ce, 1'b0);
      chk("t5_rvalid", bus.m_rvalid, (c == 1) ? 2'b01 : 2'b00);
      chk("t5_rdata", bus.m_rdata, 32'hDEAD_BEEF);
      to_next();
    end

    // 6: reset right after a read grant drops the response
    set_p(0, 1, 0, 0, 4'hF, 32'h24, 0);
    to_neg();
    chk("t6_gnt", bus.m_gnt, 2'b01);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    to_neg();
    chk("t6_rvalid", bus.m_rvalid, 2'b00);
    chk("t6_ce", bus.ram_ce, 1'b0);
    to_next();
    rst = 1'b0;
    set_p(0, 1, 0, 0, 4'hF, 32'h10, 0);
    set_p(1, 1, 0, 0, 4'hF, 32'h14, 0);
    to_neg();
    chk("t6_tie_gnt", bus.m_gnt, 2'b01);
    to_next();
    idle_inputs();
    to_neg();
    chk("t6_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    to_next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
